// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - DataFlash opcodes, arbiter FSM encoding and opcode helpers
package flash_pkg;

  typedef logic [2:0] state_t;

  localparam logic [7:0] OP_ID         = 8'h9F;
  localparam logic [7:0] OP_STATUS     = 8'hD7;
  localparam logic [7:0] OP_CONT_RD    = 8'hE8;
  localparam logic [7:0] OP_BUF1_RD    = 8'hD4;
  localparam logic [7:0] OP_BUF2_RD    = 8'hD6;
  localparam logic [7:0] OP_BUF1_WR    = 8'h84;
  localparam logic [7:0] OP_BUF2_WR    = 8'h87;
  localparam logic [7:0] OP_B1_PROG    = 8'h83;
  localparam logic [7:0] OP_B2_PROG    = 8'h86;
  localparam logic [7:0] OP_MM_PROG1   = 8'h82;
  localparam logic [7:0] OP_MM_PROG2   = 8'h85;
  localparam logic [7:0] OP_PAGE_ERASE = 8'h81;
  localparam logic [7:0] OP_CHIP_ERASE = 8'hC7;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_ISSUE      = 3'd1;
  localparam state_t ST_EXEC       = 3'd2;
  localparam state_t ST_GAP        = 3'd3;
  localparam state_t ST_POLL_ISSUE = 3'd4;
  localparam state_t ST_POLL_EXEC  = 3'd5;
  localparam state_t ST_DONE       = 3'd6;

  // Program/erase opcodes leave the part internally busy; completion needs status polling.
  function automatic logic is_busy_op(input logic [7:0] op);
    case (op)
      OP_PAGE_ERASE, OP_CHIP_ERASE, OP_MM_PROG1,
      OP_MM_PROG2, OP_B1_PROG, OP_B2_PROG: is_busy_op = 1'b1;
      default:                             is_busy_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/flash_rr_arb2.sv
// rtl/flash_rr_arb2.sv - two-way round-robin grant, pointer moves only on contention
module flash_rr_arb2
  import flash_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt,
  output logic gnt_b
);

  logic ptr_b;

  always_comb begin
    gnt   = en & (req_a | req_b);
    gnt_b = req_b & (~req_a | ptr_b);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_b <= 1'b0;
    end else if (en && req_a && req_b) begin
      ptr_b <= ~gnt_b;
    end
  end

endmodule

// File: rtl/flash_cmd_arbiter.sv
// rtl/flash_cmd_arbiter.sv - shares the DataFlash command engine between two requesters
module flash_cmd_arbiter
  import flash_pkg::*;
#(
  parameter int POLL_GAP = 1000,
  parameter int POLL_MAX = 4096,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [7:0]  cmd_a,
  input  logic [23:0] adr_a,
  output logic        ack_a,
  output logic        done_a,
  output logic        err_a,
  output logic        rvalid_a,
  input  logic        req_b,
  input  logic [7:0]  cmd_b,
  input  logic [23:0] adr_b,
  output logic        ack_b,
  output logic        done_b,
  output logic        err_b,
  output logic        rvalid_b,
  output logic [31:0] rdata,
  output logic [7:0]  fl_cmd,
  output logic [23:0] fl_adr,
  output logic        fl_wr,
  input  logic        fl_busy,
  input  logic        fl_rd,
  input  logic [31:0] fl_rddata,
  output logic        owner
);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(POLL_GAP - 1);
  localparam logic [CNT_W-1:0] POLL_LIM = CNT_W'(POLL_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [7:0]       cmd_q;
  logic [23:0]      adr_q;
  logic             skip;
  logic             ready;
  logic             err_flag;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] poll_cnt;
  logic             gnt;
  logic             gnt_b;
  logic             poll_ready;

  flash_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (state == ST_IDLE),
    .req_a (req_a),
    .req_b (req_b),
    .gnt   (gnt),
    .gnt_b (gnt_b)
  );

  // A status word arriving on the cycle busy drops still decides this poll.
  always_comb begin
    poll_ready = fl_rd ? fl_rddata[7] : ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cmd_q    <= '0;
      adr_q    <= '0;
      skip     <= 1'b0;
      ready    <= 1'b0;
      err_flag <= 1'b0;
      gap_cnt  <= '0;
      poll_cnt <= '0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      err_a    <= 1'b0;
      err_b    <= 1'b0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata    <= '0;
      fl_cmd   <= '0;
      fl_adr   <= '0;
      fl_wr    <= 1'b0;
      owner    <= 1'b0;
    end else begin
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      err_a    <= 1'b0;
      err_b    <= 1'b0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      fl_wr    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt) begin
            cmd_q <= gnt_b ? cmd_b : cmd_a;
            adr_q <= gnt_b ? adr_b : adr_a;
            owner <= gnt_b;
            ack_a <= ~gnt_b;
            ack_b <= gnt_b;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!fl_busy) begin
            fl_cmd <= cmd_q;
            fl_adr <= adr_q;
            fl_wr  <= 1'b1;
            skip   <= 1'b1;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          skip <= 1'b0;
          if (fl_rd) begin
            rdata    <= fl_rddata;
            rvalid_a <= ~owner;
            rvalid_b <= owner;
          end
          if (!skip && !fl_busy) begin
            if (is_busy_op(cmd_q)) begin
              poll_cnt <= '0;
              gap_cnt  <= '0;
              state    <= ST_GAP;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt >= GAP_LAST) begin
            state <= ST_POLL_ISSUE;
          end else begin
            gap_cnt <= gap_cnt + CNT_ONE;
          end
        end
        ST_POLL_ISSUE: begin
          if (!fl_busy) begin
            fl_cmd <= OP_STATUS;
            fl_wr  <= 1'b1;
            skip   <= 1'b1;
            ready  <= 1'b0;
            if (poll_cnt != '1) poll_cnt <= poll_cnt + CNT_ONE;
            state  <= ST_POLL_EXEC;
          end
        end
        ST_POLL_EXEC: begin
          skip <= 1'b0;
          if (fl_rd) ready <= fl_rddata[7];
          if (!skip && !fl_busy) begin
            if (poll_ready) begin
              state <= ST_DONE;
            end else if (poll_cnt >= POLL_LIM) begin
              err_flag <= 1'b1;
              state    <= ST_DONE;
            end else begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end
          end
        end
        ST_DONE: begin
          done_a   <= ~owner;
          done_b   <= owner;
          err_a    <= err_flag & ~owner;
          err_b    <= err_flag & owner;
          err_flag <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cmd_arbiter.sv
// tb/tb_flash_cmd_arbiter.sv - randomized self-checking bench with engine model and scoreboard
module tb_flash_cmd_arbiter;

  localparam int POLL_GAP = 6;
  localparam int POLL_MAX = 4;
  localparam int BUDGET   = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [7:0]  cmd_a = '0, cmd_b = '0;
  logic [23:0] adr_a = '0, adr_b = '0;
  logic        ack_a, done_a, err_a, rvalid_a;
  logic        ack_b, done_b, err_b, rvalid_b;
  logic [31:0] rdata;
  logic [7:0]  fl_cmd;
  logic [23:0] fl_adr;
  logic        fl_wr;
  logic        fl_busy = 1'b0;
  logic        fl_rd = 1'b0;
  logic [31:0] fl_rddata = '0;
  logic        owner;

  int total = 0;
  int bad = 0;

  flash_cmd_arbiter #(.POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .cmd_a(cmd_a), .adr_a(adr_a), .ack_a(ack_a), .done_a(done_a),
    .err_a(err_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .cmd_b(cmd_b), .adr_b(adr_b), .ack_b(ack_b), .done_b(done_b),
    .err_b(err_b), .rvalid_b(rvalid_b),
    .rdata(rdata), .fl_cmd(fl_cmd), .fl_adr(fl_adr), .fl_wr(fl_wr),
    .fl_busy(fl_busy), .fl_rd(fl_rd), .fl_rddata(fl_rddata), .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- engine model: one script step per cycle ----------------
  typedef struct packed {logic busy; logic rd; logic [31:0] data;} step_t;
  step_t       script[$];
  logic [31:0] cmd_words[$];
  int          stat_q[$];
  step_t       cur;

  function automatic step_t mk(input logic b, input logic r, input logic [31:0] d);
    mk = {b, r, d};
  endfunction

  task automatic build(input logic [7:0] c);
    int st;
    logic [31:0] w;
    script.push_back(mk(1'b1, 1'b0, 32'h0));
    if (c == 8'hD7) begin
      st = -1;
      if (stat_q.size() > 0) st = stat_q.pop_front();
      if (st >= 0) begin
        w = $urandom();
        w[7:0] = st[7:0];
        script.push_back(mk(1'b1, 1'b1, w));
        script.push_back(mk(1'b1, 1'b0, 32'h0));
      end
    end else begin
      while (cmd_words.size() > 0) begin
        script.push_back(mk(1'b1, 1'b1, cmd_words.pop_front()));
        script.push_back(mk(1'b1, 1'b0, 32'h0));
      end
    end
    repeat ($urandom_range(3, 0)) script.push_back(mk(1'b1, 1'b0, 32'h0));
    script.push_back(mk(1'b0, 1'b0, 32'h0));
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    if (!rst) begin
      script.delete();
      fl_busy = 1'b0;
      fl_rd = 1'b0;
    end else begin
      if (fl_wr) build(fl_cmd);
      if (script.size() > 0) begin
        cur = script.pop_front();
        fl_busy = cur.busy;
        fl_rd = cur.rd;
        fl_rddata = cur.data;
      end else begin
        fl_busy = 1'b0;
        fl_rd = 1'b0;
      end
    end
  end

  // Requesters hold req until they see their ack.
  initial forever begin
    @(negedge clk);
    if (ack_a) req_a = 1'b0;
    if (ack_b) req_b = 1'b0;
  end

  // ---------------- monitor ----------------
  int          n_ack_a, n_ack_b, n_done_a, n_done_b, n_err_a, n_err_b;
  int          n_poll, n_wr, n_wr_busy, n_err_nodone, n_gap_bad, n_adr_bad, idle_run;
  logic [7:0]  wr_cmd0;
  logic [23:0] wr_adr0, last_adr;
  logic [31:0] rv_a[$], rv_b[$];
  int          ack_order[$];

  task automatic clear_mon();
    n_ack_a = 0; n_ack_b = 0; n_done_a = 0; n_done_b = 0; n_err_a = 0; n_err_b = 0;
    n_poll = 0; n_wr = 0; n_wr_busy = 0; n_err_nodone = 0; n_gap_bad = 0; n_adr_bad = 0;
    wr_cmd0 = '0; wr_adr0 = '0;
    rv_a.delete(); rv_b.delete(); ack_order.delete();
  endtask

  initial begin
    clear_mon();
    idle_run = 0;
    last_adr = '0;
    forever begin
      @(negedge clk);
      if (ack_a) begin n_ack_a++; ack_order.push_back(0); end
      if (ack_b) begin n_ack_b++; ack_order.push_back(1); end
      if (rvalid_a) rv_a.push_back(rdata);
      if (rvalid_b) rv_b.push_back(rdata);
      if (done_a) n_done_a++;
      if (done_b) n_done_b++;
      if (err_a) n_err_a++;
      if (err_b) n_err_b++;
      if ((err_a && !done_a) || (err_b && !done_b)) n_err_nodone++;
      if (fl_wr) begin
        if (fl_busy) n_wr_busy++;
        if (n_wr == 0) begin wr_cmd0 = fl_cmd; wr_adr0 = fl_adr; end
        n_wr++;
        if (fl_cmd == 8'hD7) begin
          n_poll++;
          if (idle_run < POLL_GAP || idle_run > POLL_GAP + 2) n_gap_bad++;
          if (fl_adr != last_adr) n_adr_bad++;
        end else begin
          last_adr = fl_adr;
        end
        idle_run = 0;
      end else if (!fl_busy) begin
        idle_run++;
      end
    end
  end

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while (n_done_a + n_done_b < n && t < BUDGET) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("done_in_budget", 32'(t < BUDGET), 32'd1);
  endtask

  // One transaction checked against the opcode rules: busy ops poll until a
  // ready status or POLL_MAX polls, everything else completes straight away.
  task automatic run_txn(input bit port, input logic [7:0] op, input logic [23:0] adr,
                         input int nwords, input int nnot, input bit rand_stat);
    logic [31:0] exp_w[$];
    logic [31:0] got[$];
    logic [31:0] w;
    bit busy_op, exp_err;
    int exp_polls;
    clear_mon();
    cmd_words.delete();
    stat_q.delete();
    for (int i = 0; i < nwords; i++) begin
      w = $urandom();
      exp_w.push_back(w);
      cmd_words.push_back(w);
    end
    for (int i = 0; i < nnot; i++) begin
      if (!rand_stat) stat_q.push_back(0);
      else if ($urandom_range(1, 0) == 1) stat_q.push_back(int'($urandom_range(127, 0)));
      else stat_q.push_back(-1);
    end
    stat_q.push_back(rand_stat ? int'($urandom_range(255, 128)) : 128);
    busy_op = op inside {8'h81, 8'hC7, 8'h82, 8'h85, 8'h83, 8'h86};
    exp_polls = !busy_op ? 0 : ((nnot + 1 <= POLL_MAX) ? nnot + 1 : POLL_MAX);
    exp_err = busy_op && (nnot >= POLL_MAX);
    if (port) begin cmd_b = op; adr_b = adr; req_b = 1'b1; end
    else begin cmd_a = op; adr_a = adr; req_a = 1'b1; end
    wait_done(1);
    got = port ? rv_b : rv_a;
    chk("ack_count", 32'(port ? n_ack_b : n_ack_a), 32'd1);
    chk("done_count", 32'(port ? n_done_b : n_done_a), 32'd1);
    chk("other_done", 32'(port ? n_done_a : n_done_b), 32'd0);
    chk("err_flag", 32'(port ? n_err_b : n_err_a), 32'(exp_err));
    chk("poll_count", 32'(n_poll), 32'(exp_polls));
    chk("issued_cmd", {24'h0, wr_cmd0}, {24'h0, op});
    chk("issued_adr", {8'h0, wr_adr0}, {8'h0, adr});
    chk("rvalid_count", 32'(got.size()), 32'(nwords));
    chk("other_rvalid", 32'(port ? rv_a.size() : rv_b.size()), 32'd0);
    for (int i = 0; i < got.size() && i < nwords; i++) chk("rdata_word", got[i], exp_w[i]);
    chk("wr_while_busy", 32'(n_wr_busy), 32'd0);
    chk("poll_gap", 32'(n_gap_bad), 32'd0);
    chk("poll_adr", 32'(n_adr_bad), 32'd0);
    chk("err_without_done", 32'(n_err_nodone), 32'd0);
    chk("owner", 32'(owner), 32'(port));
  endtask

  logic [7:0] ops[13] = '{8'h9F, 8'hE8, 8'hD4, 8'hD6, 8'h84, 8'h87, 8'h83,
                          8'h86, 8'h82, 8'h85, 8'h81, 8'hC7, 8'h3C};

  initial begin
    int t;
    logic [7:0] op;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_ctl", 32'({ack_a, ack_b, done_a, done_b, err_a, err_b, rvalid_a, rvalid_b, fl_wr, owner}), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_fl", {fl_cmd, fl_adr}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;

    // Uncontested ID read: ack one cycle after request, issue the cycle after.
    clear_mon();
    cmd_words.delete();
    cmd_words.push_back(32'h1F26_0000);
    cmd_a = 8'h9F; adr_a = 24'h0; req_a = 1'b1;
    @(negedge clk);
    #2;
    chk("lat_ack", 32'(ack_a), 32'd1);
    @(negedge clk);
    #2;
    chk("lat_wr", 32'({fl_wr, fl_cmd}), 32'h19F);
    wait_done(1);
    chk("id_rvalid", 32'(rv_a.size()), 32'd1);
    chk("id_rdata", rv_a.size() > 0 ? rv_a[0] : 32'hX, 32'h1F26_0000);
    chk("id_nopoll", 32'(n_poll), 32'd0);

    // Simultaneous requests: A first after reset, then B; next contention goes to B.
    clear_mon();
    cmd_a = 8'hE8; cmd_b = 8'hD4; req_a = 1'b1; req_b = 1'b1;
    wait_done(2);
    chk("rr1_first", ack_order.size() > 0 ? 32'(ack_order[0]) : 32'd9, 32'd0);
    chk("rr1_second", ack_order.size() > 1 ? 32'(ack_order[1]) : 32'd9, 32'd1);
    clear_mon();
    req_a = 1'b1; req_b = 1'b1;
    wait_done(2);
    chk("rr2_first", ack_order.size() > 0 ? 32'(ack_order[0]) : 32'd9, 32'd1);
    chk("rr2_second", ack_order.size() > 1 ? 32'(ack_order[1]) : 32'd9, 32'd0);

    // Program with two not-ready statuses, then timeout at exactly POLL_MAX polls.
    run_txn(1'b1, 8'h83, 24'h001200, 0, 2, 1'b0);
    run_txn(1'b0, 8'hC7, 24'h000000, 0, POLL_MAX, 1'b0);
    run_txn(1'b0, 8'h81, 24'h00ABCD, 0, POLL_MAX - 1, 1'b1);

    // Engine busy at grant, with stray read words while idle/issuing.
    clear_mon();
    script.push_back(mk(1'b1, 1'b1, 32'hDEAD_BEEF));
    script.push_back(mk(1'b1, 1'b0, 32'h0));
    for (int i = 0; i < 6; i++) script.push_back(mk(1'b1, i == 3, 32'hCAFE_0000 + i));
    script.push_back(mk(1'b0, 1'b0, 32'h0));
    @(negedge clk);
    #2;
    run_txn(1'b1, 8'hE8, 24'h123456, 1, 0, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 16; k++) begin
      op = ops[$urandom_range(12, 0)];
      run_txn(1'($urandom_range(1, 0)), op, 24'($urandom()),
              int'($urandom_range(3, 0)), int'($urandom_range(POLL_MAX + 1, 0)), 1'b1);
    end

    // Reset while a status poll is executing: outputs clear, no done follows.
    clear_mon();
    cmd_words.delete();
    stat_q.delete();
    for (int i = 0; i < 10; i++) stat_q.push_back(0);
    cmd_b = 8'hC7; adr_b = 24'h00F00D; req_b = 1'b1;
    t = 0;
    while (n_poll == 0 && t < BUDGET) begin @(negedge clk); #2; t++; end
    chk("poll_seen", 32'(t < BUDGET), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ctl", 32'({ack_a, ack_b, done_a, done_b, err_a, err_b, rvalid_a, rvalid_b, fl_wr, owner}), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_fl", {fl_cmd, fl_adr}, 32'd0);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    chk("arst_no_done", 32'(n_done_a + n_done_b), 32'd0);
    run_txn(1'b0, 8'h9F, 24'h000000, 1, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
